mpmc11_strm_read_seq: RTL and testbench

- Stream-read sequencer in the memory-clock domain, directly upstream of the stream read FIFO.
- Accepts a stream request (start address, strip count) and issues one memory read command per strip.
- Tracks outstanding reads and forwards returned read data as wr/wdat/last_strip to the FIFO write side.
- Throttles command issue on FIFO almost-full and on an outstanding-read limit so the FIFO never overflows.

---
 rtl/mpmc11_strm_read_seq_if.sv | 32 +++
 rtl/mpmc11_strm_read_seq.sv | 98 +++++++++
 tb/tb_mpmc11_strm_read_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpmc11_strm_read_seq_if.sv
// mpmc11_strm_read_seq_if: request, read-command, read-return and FIFO-write signals of the stream read sequencer
interface mpmc11_strm_read_seq_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_adr;
    logic [CNT_W-1:0]  req_nstrips;
    logic              abort;
    logic              cmd_en;
    logic              cmd_rdy;
    logic [ADDR_W-1:0] cmd_adr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              fifo_afull;
    logic              wr;
    logic [DATA_W-1:0] wdat;
    logic              last_strip;
    logic              busy;
    logic              done;
    logic              err;
    modport master (
        output req_valid, req_adr, req_nstrips, abort, cmd_rdy, rd_valid, rd_data, fifo_afull,
        input  req_ready, cmd_en, cmd_adr, wr, wdat, last_strip, busy, done, err
    );
    modport slave (
        input  req_valid, req_adr, req_nstrips, abort, cmd_rdy, rd_valid, rd_data, fifo_afull,
        output req_ready, cmd_en, cmd_adr, wr, wdat, last_strip, busy, done, err
    );
endinterface

// File: rtl/mpmc11_strm_read_seq.sv
// mpmc11_strm_read_seq: issues one read command per strip of a stream request and forwards
// the in-order read data to the stream FIFO, throttled by FIFO almost-full and an outstanding limit.
module mpmc11_strm_read_seq #(
    parameter int DATA_W      = 256,
    parameter int ADDR_W      = 32,
    parameter int STRIP_BYTES = 32,
    parameter int MAX_OUT     = 16,
    parameter int CNT_W       = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    mpmc11_strm_read_seq_if.slave bus
);
    localparam int SB_W  = $clog2(STRIP_BYTES);
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t            state, state_d;
    logic [ADDR_W-1:0] base, cmd_adr_q, cmd_adr_d;
    logic [CNT_W-1:0]  nstrips, issue_cnt, ret_cnt, issue_nxt;
    logic [OUT_W-1:0]  out_cnt, out_nxt;
    logic [DATA_W-1:0] wdat_q;
    logic              aborted, aborted_d, cmd_en_q, cmd_en_d;
    logic              wr_q, last_q, done_q, err_q;
    logic              accept, active, xfer, fire;
    assign accept    = bus.req_valid & (state == IDLE);
    assign active    = (state == ISSUE) | (state == DRAIN);
    assign xfer      = cmd_en_q & bus.cmd_rdy;
    // outstanding count is zero outside ISSUE/DRAIN, so this also gates returns to those states
    assign fire      = bus.rd_valid & (out_cnt != '0);
    assign issue_nxt = issue_cnt + CNT_W'(xfer);
    assign out_nxt   = out_cnt + OUT_W'(xfer) - OUT_W'(fire);
    assign bus.req_ready  = state == IDLE;
    assign bus.busy       = state != IDLE;
    assign bus.cmd_en     = cmd_en_q;
    assign bus.cmd_adr    = cmd_adr_q;
    assign bus.wr         = wr_q;
    assign bus.wdat       = wdat_q;
    assign bus.last_strip = last_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    always_comb begin
        state_d   = state;
        aborted_d = aborted | (active & bus.abort);
        cmd_en_d  = cmd_en_q & ~bus.cmd_rdy;
        cmd_adr_d = cmd_adr_q;
        // a presented command is held until accepted; a new one is only chosen once the slot frees
        if (state == ISSUE && !aborted_d && (!cmd_en_q || bus.cmd_rdy)) begin
            cmd_en_d  = (issue_nxt < nstrips) & (out_nxt < OUT_W'(MAX_OUT)) & ~bus.fifo_afull;
            cmd_adr_d = base + (ADDR_W'(issue_nxt) << SB_W);
        end
        case (state)
            IDLE:  if (accept) state_d = (bus.req_nstrips == '0) ? DONE : ISSUE;
            ISSUE: if (aborted_d || issue_nxt == nstrips) state_d = DRAIN;
            DRAIN: if (out_nxt == '0 && !cmd_en_d) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            nstrips   <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            out_cnt   <= '0;
            aborted   <= 1'b0;
            cmd_en_q  <= 1'b0;
            cmd_adr_q <= '0;
            wr_q      <= 1'b0;
            wdat_q    <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_en_q  <= cmd_en_d;
            cmd_adr_q <= cmd_adr_d;
            wr_q      <= fire & ~aborted;
            last_q    <= fire & ~aborted & (ret_cnt == nstrips - CNT_W'(1));
            done_q    <= state == DONE;
            err_q     <= bus.rd_valid & (out_cnt == '0);
            if (fire && !aborted) wdat_q <= bus.rd_data;
            if (accept) begin
                base      <= bus.req_adr & ~ADDR_W'(STRIP_BYTES - 1);
                nstrips   <= bus.req_nstrips;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                out_cnt   <= '0;
                aborted   <= 1'b0;
            end else begin
                issue_cnt <= issue_nxt;
                ret_cnt   <= ret_cnt + CNT_W'(fire);
                out_cnt   <= out_nxt;
                aborted   <= aborted_d;
            end
        end
    end
endmodule

// File: tb/tb_mpmc11_strm_read_seq.sv
// tb_mpmc11_strm_read_seq: directed streams against a stream-level model with a per-cycle compare
// process, a latency-driven memory responder, and literal checks of the key scenarios.
module tb_mpmc11_strm_read_seq;
    localparam int DW = 256, AW = 32, SB = 32, MO = 16, CW = 8, LAT = 3;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;
    mpmc11_strm_read_seq_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus();
    mpmc11_strm_read_seq #(.DATA_W(DW), .ADDR_W(AW), .STRIP_BYTES(SB), .MAX_OUT(MO), .CNT_W(CW))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0, bad = 0, cyc = 0;
    int credit = 1 << 30;
    logic inj = 1'b0;
    logic [AW-1:0] mq[$];
    int mt[$];
    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
        return {4{a, ~a}} ^ {DW/32{32'h0F0F_5A5A}};
    endfunction
    // memory: each accepted command returns one beat LAT cycles later, gated by credit
    initial begin
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(posedge clk); #2;
            if (inj) begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = dat(32'hDEAD);
            end else if (mq.size() > 0 && mt[0] <= cyc + 1 && credit > 0) begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = dat(mq.pop_front());
                void'(mt.pop_front());
                credit--;
            end else bus.rd_valid = 1'b0;
        end
    end
    logic e_wr = 0, e_last = 0, e_err = 0, e_busy = 0, m_act = 0, m_ab = 0, prev_af = 0, prev_en = 0;
    logic [DW-1:0] e_wdat = '0;
    logic [AW-1:0] m_base = '0, mexp;
    logic [AW-1:0] mdq[$];
    logic [AW-1:0] clog[$];
    int m_n = 0, m_iss = 0, m_ret = 0, m_out = 0, done_at = -1;
    int n_cmd = 0, n_wr = 0, n_last = 0, n_err = 0, n_done = 0, last_wr_cyc = 0, done_cyc = 0, acc_cyc = 0;
    logic mf, mx, nb;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_cmd_en", bus.cmd_en, 0);
            chk("rst_cmd_adr", bus.cmd_adr, 0);
            chk("rst_wr", bus.wr, 0);
            chk("rst_wdat", bus.wdat, 0);
            chk("rst_last", bus.last_strip, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_err", bus.err, 0);
            chk("rst_req_ready", bus.req_ready, 1);
            {e_wr, e_last, e_err, e_busy, m_act, m_ab, prev_af, prev_en} = '0;
            m_out = 0;
            done_at = -1;
            mdq.delete();
        end else begin
            chk("wr", bus.wr, e_wr);
            if (e_wr) begin
                chk("wdat", bus.wdat, e_wdat);
                chk("last_strip", bus.last_strip, e_last);
            end
            chk("err", bus.err, e_err);
            chk("done", bus.done, cyc == done_at);
            chk("busy", bus.busy, e_busy);
            chk("req_ready", bus.req_ready, !e_busy);
            if (prev_af && !prev_en) chk("afull_stop", bus.cmd_en, 0);
            if (bus.wr) begin n_wr++; last_wr_cyc = cyc; if (bus.last_strip) n_last++; end
            if (bus.err) n_err++;
            if (bus.done) begin n_done++; done_cyc = cyc; end
            mf = bus.rd_valid && m_out > 0;
            mx = bus.cmd_en && bus.cmd_rdy;
            e_err = bus.rd_valid && m_out == 0;
            e_wr = mf && !m_ab;
            e_last = e_wr && (m_ret == m_n - 1);
            if (mf) begin e_wdat = dat(mdq.pop_front()); m_ret++; end
            if (mx) begin
                mexp = m_base + AW'(m_iss * SB);
                chk("cmd_adr", bus.cmd_adr, mexp);
                chk("cmd_in_stream", m_act && m_iss < m_n, 1);
                chk("cmd_window", m_out < MO, 1);
                mdq.push_back(bus.cmd_adr);
                mq.push_back(bus.cmd_adr);
                mt.push_back(cyc + LAT);
                clog.push_back(bus.cmd_adr);
                m_iss++;
                n_cmd++;
            end
            m_out = m_out + int'(mx) - int'(mf);
            if (bus.abort && m_act) m_ab = 1;
            nb = e_busy && done_at != cyc + 1;
            if (bus.req_valid && !e_busy) begin
                m_base = bus.req_adr & ~AW'(SB - 1);
                m_n = int'(bus.req_nstrips);
                {m_iss, m_ret, m_out} = '0;
                m_ab = 0;
                m_act = 1;
                nb = 1;
                acc_cyc = cyc;
                if (m_n == 0) begin done_at = cyc + 2; m_act = 0; end
            end else if (m_act && mf && m_out == 0 && (m_ab ? !bus.cmd_en : m_ret == m_n)) begin
                done_at = cyc + 2;
                m_act = 0;
            end
            e_busy = nb;
            prev_af = bus.fifo_afull;
            prev_en = bus.cmd_en;
        end
    end
    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (bus.req_ready && !bus.done) return;
        end
        chk("idle_timeout", 0, 1);
    endtask
    task automatic wait_done(input string nm);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (bus.done) return;
        end
        chk(nm, 0, 1);
    endtask
    task automatic wait_cnt(input string nm, input int base_v, input int want, input bit use_wr);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if ((use_wr ? n_wr : n_cmd) - base_v >= want) return;
        end
        chk(nm, 0, 1);
    endtask
    task automatic req(input logic [AW-1:0] a, input int n);
        wait_idle();
        @(posedge clk); #2;
        bus.req_valid = 1'b1;
        bus.req_adr = a;
        bus.req_nstrips = CW'(n);
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
    endtask
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        int c0, w0, l0, e0, s0, stall_x, sz;
        bus.req_valid = 0; bus.req_adr = '0; bus.req_nstrips = '0; bus.abort = 0;
        bus.cmd_rdy = 1; bus.fifo_afull = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        // basic 4-strip stream
        c0 = clog.size(); w0 = n_wr; l0 = n_last;
        req(32'h1000, 4);
        wait_done("t1_done_timeout");
        repeat (2) @(posedge clk);
        chk("t1_adr0", clog[c0], 32'h1000);
        chk("t1_adr1", clog[c0 + 1], 32'h1020);
        chk("t1_adr2", clog[c0 + 2], 32'h1040);
        chk("t1_adr3", clog[c0 + 3], 32'h1060);
        chk("t1_wr_count", n_wr - w0, 4);
        chk("t1_last_count", n_last - l0, 1);
        chk("t1_done_after_wr", done_cyc - last_wr_cyc, 1);
        // outstanding limit with data held off, unaligned start address
        credit = 0;
        c0 = n_cmd; w0 = n_wr; e0 = n_err;
        req(32'h2011, 40);
        repeat (60) @(posedge clk);
        @(negedge clk); #1;
        chk("t2_held_cmds", n_cmd - c0, MO);
        chk("t2_held_cmd_en", bus.cmd_en, 0);
        credit = 1 << 30;
        wait_done("t2_done_timeout");
        repeat (2) @(posedge clk);
        chk("t2_cmds", n_cmd - c0, 40);
        chk("t2_wr", n_wr - w0, 40);
        chk("t2_err", n_err - e0, 0);
        // fifo almost-full window
        c0 = n_cmd; w0 = n_wr; stall_x = 0;
        req(32'h3000, 10);
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #2;
            bus.fifo_afull = (k >= 5 && k < 20);
            @(negedge clk);
            if (k >= 7 && k < 20 && bus.cmd_en && bus.cmd_rdy) stall_x++;
        end
        wait_done("t3_done_timeout");
        repeat (2) @(posedge clk);
        chk("t3_afull_cmds", stall_x, 0);
        chk("t3_cmds", n_cmd - c0, 10);
        chk("t3_wr", n_wr - w0, 10);
        // zero-strip request
        c0 = n_cmd; w0 = n_wr; s0 = n_done;
        req(32'h4000, 0);
        wait_done("t4_done_timeout");
        repeat (2) @(posedge clk);
        chk("t4_done_latency", done_cyc - acc_cyc, 2);
        chk("t4_done_count", n_done - s0, 1);
        chk("t4_cmds", n_cmd - c0, 0);
        chk("t4_wr", n_wr - w0, 0);
        // abort with 2 reads outstanding
        credit = 0;
        c0 = n_cmd; w0 = n_wr; s0 = n_done;
        req(32'h5000, 8);
        wait_cnt("t5_cmd_timeout", c0, 2, 0);
        @(posedge clk); #2 bus.fifo_afull = 1'b1;
        repeat (3) @(posedge clk);
        credit = 1;
        wait_cnt("t5_wr_timeout", w0, 1, 1);
        repeat (2) @(posedge clk);
        #2 bus.abort = 1'b1;
        @(posedge clk); #2;
        bus.abort = 1'b0;
        bus.fifo_afull = 1'b0;
        credit = 1 << 30;
        wait_done("t5_done_timeout");
        @(negedge clk); #1;
        chk("t5_req_ready", bus.req_ready, 1);
        repeat (4) @(posedge clk);
        chk("t5_cmds", n_cmd - c0, 3);
        chk("t5_wr", n_wr - w0, 1);
        chk("t5_done_count", n_done - s0, 1);
        // read data while idle
        wait_idle();
        e0 = n_err; w0 = n_wr;
        @(posedge clk); #2 inj = 1'b1;
        @(posedge clk); #2 inj = 1'b0;
        repeat (3) @(posedge clk);
        chk("t6_err", n_err - e0, 1);
        chk("t6_wr", n_wr - w0, 0);
        // asynchronous reset mid-stream; held returns then arrive as errors
        c0 = n_cmd;
        req(32'h7000, 20);
        wait_cnt("t7_cmd_timeout", c0, 5, 0);
        credit = 0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t7_async_cmd_en", bus.cmd_en, 0);
        chk("t7_async_cmd_adr", bus.cmd_adr, 0);
        chk("t7_async_busy", bus.busy, 0);
        chk("t7_async_req_ready", bus.req_ready, 1);
        chk("t7_async_wr", bus.wr, 0);
        chk("t7_async_wdat", bus.wdat, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        sz = mq.size();
        e0 = n_err;
        credit = 1 << 30;
        repeat (MO + 10) @(posedge clk);
        chk("t7_inflight_seen", sz > 0, 1);
        chk("t7_inflight_err", n_err - e0, sz);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
